// File: rtl/data_mem_pkg.sv
// Shared types and width helpers for the data memory controller.
//   state_t  : controller FSM states
//   region_t : address decode result (on-chip RAM or external DRAM)
//   sel_w    : bits needed to select one of n items (at least 1)
//   cnt_w    : bits needed to hold the values 0..n
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOCAL_WAIT = 2'd1,
        DRAM_WAIT  = 2'd2,
        RESP       = 2'd3
    } state_t;

    typedef enum logic {
        LOCAL = 1'b0,
        DRAM  = 1'b1
    } region_t;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-enabled single-port RAM with a LAT-stage registered read pipeline.
//   clk     : clock
//   en_i    : access enable (read when we_i=0, write when we_i=1)
//   we_i    : write select
//   wstrb_i : byte-lane write enables
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : read data, valid LAT cycles after the read cycle
module byte_ram #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 4096,
    parameter int LAT    = 1
) (
    input  logic                     clk,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [DATA_W/8-1:0]      wstrb_i,
    input  logic [$clog2(WORDS)-1:0] idx_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem    [WORDS];
    logic [DATA_W-1:0] pipe_q [LAT];

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int unsigned b = 0; b < DATA_W / 8; b++) begin
                if (wstrb_i[b]) begin
                    mem[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (en_i && !we_i) begin
            pipe_q[0] <= mem[idx_i];
        end
        for (int unsigned s = 1; s < LAT; s++) begin
            pipe_q[s] <= pipe_q[s-1];
        end
    end

    assign rdata_o = pipe_q[LAT-1];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: arbitrated single-outstanding request from NPORT
// requesters, decoded to on-chip byte RAM or an external DRAM interface.
//   clk, rstn                 : clock, async active-low reset
//   port_sel                  : which port may start a request
//   req_valid/we/addr/wdata/wstrb : per-port request (packed per port)
//   rsp_ready                 : one-cycle completion pulse to owning port
//   rsp_rdata                 : last successful read data (shared)
//   rsp_err                   : error flag, valid with rsp_ready
//   busy                      : controller not idle
//   dram_valid/rw/addr/din/wstrb : external request (zero when idle)
//   dram_dout, dram_ready     : external read data and completion
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int NPORT        = 2,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int LOCAL_BYTES  = 16384,
    parameter int LOCAL_LAT    = 1,
    parameter int DRAM_ADDR_W  = 27,
    parameter int DRAM_TIMEOUT = 1023
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [sel_w(NPORT)-1:0]    port_sel,
    input  logic [NPORT-1:0]           req_valid,
    input  logic [NPORT-1:0]           req_we,
    input  logic [NPORT*ADDR_W-1:0]    req_addr,
    input  logic [NPORT*DATA_W-1:0]    req_wdata,
    input  logic [NPORT*DATA_W/8-1:0]  req_wstrb,
    output logic [NPORT-1:0]           rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       dram_valid,
    output logic                       dram_rw,
    output logic [DRAM_ADDR_W-1:0]     dram_addr,
    output logic [DATA_W-1:0]          dram_din,
    output logic [DATA_W/8-1:0]        dram_wstrb,
    input  logic [DATA_W-1:0]          dram_dout,
    input  logic                       dram_ready
);

    localparam int PSEL_W  = sel_w(NPORT);
    localparam int STRB_W  = DATA_W / 8;
    localparam int LOC_AW  = $clog2(LOCAL_BYTES);
    localparam int CNT_MAX = (DRAM_TIMEOUT > LOCAL_LAT) ? DRAM_TIMEOUT : LOCAL_LAT;
    localparam int CNT_W   = cnt_w(CNT_MAX);

    state_t              state_q, state_d;
    region_t             region_q, region_d;
    logic [PSEL_W-1:0]   port_q, port_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                ram_en;
    logic [DATA_W-1:0]   ram_rdata;

    // Region and alignment are decoded from the value being latched, so the
    // first wait state is already known at the accepting edge.
    always_comb begin
        int unsigned       sel_idx;
        logic              sel_ok;
        logic [ADDR_W-1:0] in_addr;
        logic              in_local;
        logic              in_mis;

        sel_idx  = int'(port_sel);
        sel_ok   = sel_idx < NPORT;
        in_addr  = req_addr[sel_idx*ADDR_W +: ADDR_W];
        in_local = (in_addr >> LOC_AW) == '0;
        in_mis   = in_addr[1:0] != 2'b00;

        state_d  = state_q;
        region_d = region_q;
        port_d   = port_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (sel_ok && req_valid[sel_idx]) begin
                    port_d   = port_sel;
                    we_d     = req_we[sel_idx];
                    addr_d   = in_addr;
                    wdata_d  = req_wdata[sel_idx*DATA_W +: DATA_W];
                    wstrb_d  = req_wstrb[sel_idx*STRB_W +: STRB_W];
                    region_d = in_local ? LOCAL : DRAM;
                    err_d    = in_mis;
                    cnt_d    = '0;
                    // Misaligned accesses of either region take the short
                    // local path with no memory access.
                    state_d  = (in_mis || in_local) ? LOCAL_WAIT : DRAM_WAIT;
                end
            end
            LOCAL_WAIT: begin
                if (we_q || err_q) begin
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(LOCAL_LAT)) begin
                    state_d = RESP;
                    rdata_d = ram_rdata;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAM_WAIT: begin
                if (dram_ready) begin
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = dram_dout;
                    end
                end else if (cnt_q == CNT_W'(DRAM_TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            region_q <= LOCAL;
            port_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            region_q <= region_d;
            port_q   <= port_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign ram_en = (state_q == LOCAL_WAIT) && (region_q == LOCAL) && !err_q;

    byte_ram #(
        .DATA_W (DATA_W),
        .WORDS  (LOCAL_BYTES / 4),
        .LAT    (LOCAL_LAT)
    ) u_byte_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (we_q),
        .wstrb_i (wstrb_q),
        .idx_i   (addr_q[LOC_AW-1:2]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign busy       = state_q != IDLE;
    assign rsp_ready  = (state_q == RESP) ? (NPORT'(1) << port_q) : '0;
    assign rsp_err    = (state_q == RESP) && err_q;
    assign rsp_rdata  = rdata_q;

    assign dram_valid = state_q == DRAM_WAIT;
    assign dram_rw    = dram_valid && we_q;
    assign dram_addr  = dram_valid ? addr_q[DRAM_ADDR_W:1] : '0;
    assign dram_din   = dram_valid ? wdata_q : '0;
    assign dram_wstrb = dram_valid ? wstrb_q : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (NPORT=2, 32-bit, LOCAL_LAT=1,
// DRAM_TIMEOUT=8). Expected values are hand-computed constants.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [0:0]  port_sel = '0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        dram_valid;
    logic        dram_rw;
    logic [26:0] dram_addr;
    logic [31:0] dram_din;
    logic [3:0]  dram_wstrb;
    logic [31:0] dram_dout = '0;
    logic        dram_ready = 1'b0;

    int total = 0;
    int bad = 0;
    int n;
    int vcnt;
    logic saw_dram;

    data_mem_ctrl #(
        .NPORT        (2),
        .DATA_W       (32),
        .ADDR_W       (32),
        .LOCAL_BYTES  (16384),
        .LOCAL_LAT    (1),
        .DRAM_ADDR_W  (27),
        .DRAM_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .port_sel   (port_sel),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .dram_valid (dram_valid),
        .dram_rw    (dram_rw),
        .dram_addr  (dram_addr),
        .dram_din   (dram_din),
        .dram_wstrb (dram_wstrb),
        .dram_dout  (dram_dout),
        .dram_ready (dram_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request on port p and clock the accepting edge.
    task automatic issue(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        port_sel = 1'(p);
        req_valid = '0;
        req_valid[p] = 1'b1;
        req_we = '0;
        req_we[p] = we;
        req_addr[p*32 +: 32] = a;
        req_wdata[p*32 +: 32] = d;
        req_wstrb[p*4 +: 4] = s;
        saw_dram = 1'b0;
        tick();
    endtask

    // Count cycles from the accepting edge until rsp_ready rises (bounded).
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        if (dram_valid) saw_dram = 1'b1;
        while (rsp_ready == '0 && cyc < 40) begin
            tick();
            cyc++;
            if (dram_valid) saw_dram = 1'b1;
        end
    endtask

    task automatic release_req();
        req_valid = '0;
        tick();
    endtask

    initial begin
        // Asynchronous reset assertion
        #2 rstn = 1'b0;
        #1;
        check("rst_ready", rsp_ready, 2'b00);
        check("rst_err", rsp_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dvalid", dram_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_daddr", dram_addr, 27'h0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Local full-word write, then read back
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("wr_busy", busy, 1'b1);
        wait_rsp(n);
        check("wr_lat", n, 2);
        check("wr_ready", rsp_ready, 2'b01);
        check("wr_err", rsp_err, 1'b0);
        check("wr_rdata_hold", rsp_rdata, 32'h0);
        release_req();
        check("wr_ready_drop", rsp_ready, 2'b00);
        check("wr_idle", busy, 1'b0);

        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        req_addr[31:0] = 32'h20;  // changed after acceptance: must be ignored
        wait_rsp(n);
        check("rd_lat", n, 3);
        check("rd_ready", rsp_ready, 2'b01);
        check("rd_data", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", rsp_err, 1'b0);
        release_req();

        // Byte strobe over a zeroed word
        issue(0, 1'b1, 32'h20, 32'h0, 4'hF);
        wait_rsp(n);
        release_req();
        issue(0, 1'b1, 32'h20, 32'h11223344, 4'h2);
        wait_rsp(n);
        check("strb_wr_lat", n, 2);
        release_req();
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(n);
        check("strb_rd", rsp_rdata, 32'h00003300);
        release_req();

        // All-zero strobe changes nothing and completes normally
        issue(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        wait_rsp(n);
        check("zstrb_lat", n, 2);
        check("zstrb_err", rsp_err, 1'b0);
        check("zstrb_hold", rsp_rdata, 32'h00003300);
        release_req();
        issue(0, 1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(n);
        check("zstrb_rd", rsp_rdata, 32'h00003300);
        release_req();

        // DRAM read, dram_ready sampled on the 5th valid cycle
        issue(0, 1'b0, 32'h4000, 32'h0, 4'h0);
        check("dr_addr", dram_addr, 27'h2000);
        check("dr_rw", dram_rw, 1'b0);
        vcnt = 0;
        for (int k = 1; k <= 5; k++) begin
            if (dram_valid) vcnt++;
            if (k == 5) begin
                dram_ready = 1'b1;
                dram_dout = 32'hCAFE0001;
            end
            tick();
        end
        dram_ready = 1'b0;
        dram_dout = 32'h0;
        check("dr_vcnt", vcnt, 5);
        check("dr_ready", rsp_ready, 2'b01);
        check("dr_vdrop", dram_valid, 1'b0);
        check("dr_addr_zero", dram_addr, 27'h0);
        check("dr_data", rsp_rdata, 32'hCAFE0001);
        check("dr_err", rsp_err, 1'b0);
        release_req();

        // DRAM write from port 1, ready on first valid cycle
        issue(1, 1'b1, 32'h4008, 32'hA5A55A5A, 4'h5);
        check("dw_rw", dram_rw, 1'b1);
        check("dw_addr", dram_addr, 27'h2004);
        check("dw_din", dram_din, 32'hA5A55A5A);
        check("dw_strb", dram_wstrb, 4'h5);
        dram_ready = 1'b1;
        tick();
        dram_ready = 1'b0;
        check("dw_ready", rsp_ready, 2'b10);
        check("dw_hold", rsp_rdata, 32'hCAFE0001);
        release_req();

        // DRAM timeout
        issue(0, 1'b0, 32'h8000, 32'h0, 4'h0);
        vcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (!dram_valid) break;
            vcnt++;
            tick();
        end
        check("to_vcnt", vcnt, 8);
        check("to_ready", rsp_ready, 2'b01);
        check("to_err", rsp_err, 1'b1);
        check("to_hold", rsp_rdata, 32'hCAFE0001);
        release_req();
        check("to_err_drop", rsp_err, 1'b0);

        // Misaligned read from port 1
        issue(1, 1'b0, 32'h13, 32'h0, 4'h0);
        wait_rsp(n);
        check("mis_lat", n, 2);
        check("mis_ready", rsp_ready, 2'b10);
        check("mis_err", rsp_err, 1'b1);
        check("mis_nodram", saw_dram, 1'b0);
        check("mis_hold", rsp_rdata, 32'hCAFE0001);
        release_req();

        // Unselected port's request is not accepted
        port_sel = 1'b1;
        req_valid = 2'b01;
        req_we = '0;
        req_addr[31:0] = 32'h10;
        tick();
        tick();
        check("nosel_busy", busy, 1'b0);
        check("nosel_ready", rsp_ready, 2'b00);
        req_valid = '0;

        // Reset during DRAM_WAIT
        issue(0, 1'b0, 32'h4010, 32'h0, 4'h0);
        tick();
        check("rstm_pre", dram_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check("rstm_dvalid", dram_valid, 1'b0);
        check("rstm_busy", busy, 1'b0);
        check("rstm_rdata", rsp_rdata, 32'h0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_ready != '0) vcnt++;
            tick();
        end
        check("rstm_norsp", vcnt, 0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_rsp(n);
        check("rstm_next_lat", n, 3);
        check("rstm_next_data", rsp_rdata, 32'hDEADBEEF);
        release_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Param NPORT, default 2, number of requester ports; port 0 is the core and port 1 is the I/O loader.
REQ-002 Param DATA_W, default 32, data width, a multiple of 8.
REQ-003 Param ADDR_W, default 32, byte-address width.
REQ-004 Param LOCAL_BYTES, default 16384, size of the on-chip region; must be a power of 2.
REQ-005 Param LOCAL_LAT, default 1, read latency of the local RAM in cycles, range 1..4.
REQ-006 Param DRAM_ADDR_W, default 27, width of the external address.
REQ-007 Param DRAM_TIMEOUT, default 1023, maximum cycles spent waiting for dram_ready.
REQ-008 Ports, one per line:
- clk  in  1  only clock; all state on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- port_sel  in  clog2(NPORT)  selects which port may start a request.
- req_valid  in  NPORT  per-port request; held stable until that port's rsp_ready.
- req_we  in  NPORT  per-port write (1) or read (0).
- req_addr  in  NPORT*ADDR_W  per-port byte address.
- req_wdata  in  NPORT*DATA_W  per-port write data.
- req_wstrb  in  NPORT*DATA_W/8  per-port byte-lane write enables.
- rsp_ready  out  NPORT  one-cycle completion pulse to the owning port.
- rsp_rdata  out  DATA_W  last read data, shared by all ports.
- rsp_err  out  1  error flag, valid while any rsp_ready bit is high.
- busy  out  1  high when state is not IDLE.
- dram_valid  out  1  external request.
- dram_rw  out  1  external write (1) or read (0).
- dram_addr  out  DRAM_ADDR_W  external half-word address.
- dram_din  out  DATA_W  external write data.
- dram_wstrb  out  DATA_W/8  external byte-lane enables.
- dram_dout  in  DATA_W  external read data.
- dram_ready  in  1  external completion.

Function
REQ-009 States: IDLE, LOCAL_WAIT, DRAM_WAIT, RESP.
REQ-010 Acceptance: in IDLE, a rising edge with port_sel < NPORT and req_valid[port_sel]=1 latches port, we, addr, wdata and wstrb. Later changes to port_sel or to request inputs are ignored until the next IDLE.
REQ-011 port_sel >= NPORT: no request is accepted.
REQ-012 Decode on the latched address:
- addr < LOCAL_BYTES: local access, word index addr[clog2(LOCAL_BYTES)-1:2].
- Otherwise: DRAM access, dram_addr = addr[DRAM_ADDR_W:1].
REQ-013 Misaligned access (addr[1:0] != 0): no memory access; go to RESP in the next cycle with rsp_err=1.
REQ-014 Local write: the RAM is written with wstrb lanes in the cycle after acceptance. rsp_ready rises 2 cycles after the accepting edge.
REQ-015 Local read: rsp_ready rises LOCAL_LAT+2 cycles after the accepting edge. rsp_rdata carries the RAM word in that cycle.
REQ-016 DRAM_WAIT:
- dram_valid=1, with dram_rw, dram_addr, dram_din and dram_wstrb held from the latch, until the edge that samples dram_ready=1.
- On that edge, a read captures dram_dout into rsp_rdata.
- Next state is RESP; dram_valid drops in RESP.
REQ-017 Timeout: if dram_ready is not seen within DRAM_TIMEOUT cycles, drop dram_valid, go to RESP with rsp_err=1, and leave rsp_rdata unchanged. A dram_ready arriving on the expiry edge counts as success.
REQ-018 RESP lasts exactly one cycle: rsp_ready[latched port]=1 and all other bits 0. Then return to IDLE.
REQ-019 The earliest next acceptance is the edge ending the first IDLE cycle after RESP.
REQ-020 rsp_rdata holds its value across writes, errors and idle cycles, and changes only when a read completes successfully.
REQ-021 All-zero wstrb on a write: performs no storage change and completes normally.
REQ-022 The dram_* outputs are 0 whenever dram_valid=0.

Reset
REQ-023 rstn=0 immediately forces state IDLE, rsp_ready=0, rsp_err=0, busy=0, dram_valid=0, all dram_* outputs 0, rsp_rdata=0 and the timeout counter to 0.
REQ-024 Reset mid-transaction abandons the transaction with no response. Local RAM contents are not cleared.

Structure
REQ-025 Package data_mem_pkg holds the state enum, the region enum (LOCAL, DRAM) and the width helper functions.
REQ-026 The local storage is sub-module byte_ram: byte-enabled single port, LOCAL_BYTES/4 words deep, LOCAL_LAT-stage output pipeline.

Verification
REQ-027 Local write then read, LOCAL_LAT=1: port 0 writes 0xDEADBEEF to 0x10 with wstrb=0xF, then reads 0x10 → write rsp_ready at E+2, read rsp_ready at E+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-028 Byte strobe: write 0x11223344 to 0x20 with wstrb=0x2 over 0x00000000, then read → 0x00003300.
REQ-029 DRAM read at 0x4000 with dram_ready after 5 cycles and dram_dout=0xCAFE0001 → dram_addr=0x2000, dram_valid high for 5 cycles, rsp_ready[0] the next cycle, rsp_rdata=0xCAFE0001.
REQ-030 Timeout, DRAM_TIMEOUT=8, dram_ready never asserted → dram_valid high for 8 cycles, then rsp_err=1 with rsp_ready, rsp_rdata unchanged.
REQ-031 Misaligned read at 0x13 from port 1 → rsp_ready=2'b10 and rsp_err=1 two cycles after acceptance, no RAM or DRAM activity.
REQ-032 Reset mid-DRAM_WAIT: rstn low for 1 cycle → dram_valid=0 and busy=0 immediately, no rsp_ready, next request serviced normally.
